key_updown_counter: RTL
=======================

// Module: key_updown_counter
// PURPOSE
// - Parametrised key-driven up/down counter: debounces up/down/clear keys and keeps a WIDTH-bit count.
// - Count range is [MIN_VAL, MAX_VAL], with selectable saturate or wrap mode.
// - Drives status flags and 1-cycle step pulses to the display and LED logic in the Exp2 top level.
// - Successor to the fixed 4-bit saturating key counter; adds width, limits, wrap mode, clear key and auto-repeat.
// PARAMETERS
// - F_CLK       50000000    clock frequency, Hz
// - WIDTH       4           count width, bits (1..16)
// - MIN_VAL     0           lower count limit
// - MAX_VAL     2**WIDTH-1  upper count limit; MIN_VAL < MAX_VAL <= 2**WIDTH-1
// - WRAP        0           0 = saturate at limits; 1 = wrap MAX_VAL<->MIN_VAL
// - DEB_MS      20          debounce stable time, ms; DEB_CYCLES = F_CLK/1000*DEB_MS
// - RPT_DLY_MS  500         hold time before auto-repeat starts, ms; RPT_DLY = F_CLK/1000*RPT_DLY_MS
// - RPT_PER_MS  100         auto-repeat step period, ms; RPT_PER = F_CLK/1000*RPT_PER_MS
// PORTS
// - clk        in   1      system clock
// - rst        in   1      synchronous reset, active-high
// - key_up     in   1      raw up key, asynchronous, active-low (pressed = 0)
// - key_down   in   1      raw down key, asynchronous, active-low
// - key_clr    in   1      raw clear key, asynchronous, active-low
// - count      out  WIDTH  current count value
// - up_pulse   out  1      1-cycle pulse on every applied up step
// - down_pulse out  1      1-cycle pulse on every applied down step
// - wrapped    out  1      1-cycle pulse when a step wrapped (WRAP=1 only)
// - at_max     out  1      count == MAX_VAL
// - at_min     out  1      count == MIN_VAL
// BEHAVIOUR
// - Reset, sampled on a clk edge with rst=1:
//   - count=MIN_VAL, all pulses 0, at_min=1, at_max=0.
//   - Sync flops and debounced states = 1 (released); debounce counters 0; repeat FSMs in IDLE.
// - Input path, per key:
//   - 2-flop synchroniser, then debouncer.
//   - Debounced state takes the synced value once the synced value has differed from it for DEB_CYCLES consecutive cycles.
//   - A shorter glitch resets the debounce counter; no state change.
// - Press event = debounced 1->0. Count and pulses update on the clk edge after it.
//   - Total latency from the raw falling edge is exactly DEB_CYCLES+3 cycles.
// - Step rules:
//   - Up below MAX_VAL: +1. Up at MAX_VAL: stays if WRAP=0; becomes MIN_VAL with wrapped=1 if WRAP=1.
//   - Down is symmetric at MIN_VAL.
//   - up_pulse/down_pulse assert only when the step is applied: a saturated step gives no pulse; a wrap gives a pulse.
// - Simultaneous events, same cycle:
//   - clear + anything: clear wins; count=MIN_VAL, no pulses.
//   - up + down steps: cancel; count unchanged, no pulses.
// - Clear: on the clr press event count=MIN_VAL. Holding clr does not block up/down after the clear cycle.
// - Flags at_max/at_min are registered with count; they never lag it.
// - Arithmetic is in WIDTH+1 bits internally; count never leaves [MIN_VAL, MAX_VAL].
// - Release during any FSM state returns it to IDLE next cycle; no step is emitted on release.
// CONFIGURATION
// - Macro KEY_COUNTER_AUTOREPEAT_EN.
// - Defined: each of up/down has a repeat FSM.
//   - IDLE -> HOLD on press event; that step is emitted.
//   - HOLD -> REPEAT after RPT_DLY cycles still pressed; a step is emitted on entry.
//   - REPEAT emits a step every RPT_PER cycles while pressed.
//   - Any state -> IDLE on debounced release.
//   - Repeat steps obey the saturate/wrap/simultaneity rules.
// - Undefined: no repeat FSMs or timers are synthesised. Only press events step; holding a key gives exactly one step.
// TESTING
// - Bench params: F_CLK=10000, DEB_MS=1 (DEB_CYCLES=10), RPT_DLY_MS=5, RPT_PER_MS=2, WIDTH=4.
// 1. Reset, then 3 clean up presses -> count=3, 3 up_pulses; each pulse exactly 13 cycles after the raw edge.
// 2. key_up glitch low for 6 cycles -> no change. Bouncing edge 4x3 cycles then stable low -> exactly one step.
// 3. WRAP=0, count=15, press up -> count=15, no up_pulse, at_max=1. WRAP=1 -> count=0, up_pulse=1, wrapped=1, at_min=1.
// 4. MIN_VAL=2, MAX_VAL=9, count=5: press up and down on the same cycle -> 5, no pulses. Press clr with up -> 2.
// 5. AUTOREPEAT_EN, hold up 150 cycles from count=0 -> steps at press, +50, then every 20 cycles -> count=6.
//    Without macro -> count=1.
// 6. Assert rst mid-hold in REPEAT -> next cycle count=MIN_VAL, FSM IDLE; a key still held gives no step until released and re-pressed.

Source files
------------

// File: rtl/key_updown_counter_if.sv
// Key/counter bundle between the raw key pads and the display/LED logic.
// The counter takes the slave side; whoever drives the keys takes master.
interface key_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             key_up;
    logic             key_down;
    logic             key_clr;
    logic [WIDTH-1:0] count;
    logic             up_pulse;
    logic             down_pulse;
    logic             wrapped;
    logic             at_max;
    logic             at_min;

    modport master (
        output key_up,
        output key_down,
        output key_clr,
        input  count,
        input  up_pulse,
        input  down_pulse,
        input  wrapped,
        input  at_max,
        input  at_min
    );

    modport slave (
        input  key_up,
        input  key_down,
        input  key_clr,
        output count,
        output up_pulse,
        output down_pulse,
        output wrapped,
        output at_max,
        output at_min
    );
endinterface

// File: rtl/key_updown_counter.sv
// Debounced up/down/clear key counter with saturate or wrap limits.
// Define KEY_COUNTER_AUTOREPEAT_EN to add hold-to-repeat on up/down.
module key_updown_counter #(
    parameter int F_CLK      = 50000000,
    parameter int WIDTH      = 4,
    parameter int MIN_VAL    = 0,
    parameter int MAX_VAL    = 2**WIDTH-1,
    parameter int WRAP       = 0,
    parameter int DEB_MS     = 20,
    parameter int RPT_DLY_MS = 500,
    parameter int RPT_PER_MS = 100
) (
    input logic clk,
    input logic rst,
    key_updown_counter_if.slave bus
);
    localparam int DEB_CYCLES = F_CLK / 1000 * DEB_MS;
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [WIDTH:0] MIN_W = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_VAL);

    // Key index: 0 = up, 1 = down, 2 = clear.
    logic [2:0]    raw;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    deb;
    logic [2:0]    deb_d;
    logic [2:0]    armed;
    logic [2:0]    press;
    logic [DW-1:0] dcnt [3];
    logic [DW-1:0] qcnt [3];
    logic [1:0]    step;
    logic          clr_ev;

    assign raw    = {bus.key_clr, bus.key_down, bus.key_up};
    assign press  = deb_d & ~deb & armed;
    assign clr_ev = press[2];

    // Synchronise, debounce, and arm each key only after a clean release
    // so a key held through reset cannot fire until released and re-pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '1;
            s2    <= '1;
            deb   <= '1;
            deb_d <= '1;
            armed <= '0;
            for (int i = 0; i < 3; i++) begin
                dcnt[i] <= '0;
                qcnt[i] <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_d <= deb;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_LAST) begin
                    deb[i]  <= s2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
                if (!armed[i]) begin
                    if (!s2[i]) begin
                        qcnt[i] <= '0;
                    end else if (qcnt[i] == DEB_LAST) begin
                        armed[i] <= 1'b1;
                        qcnt[i]  <= '0;
                    end else begin
                        qcnt[i] <= qcnt[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef KEY_COUNTER_AUTOREPEAT_EN
    localparam int RPT_DLY = F_CLK / 1000 * RPT_DLY_MS;
    localparam int RPT_PER = F_CLK / 1000 * RPT_PER_MS;
    localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int TW = $clog2(RPT_MAX + 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(RPT_DLY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(RPT_PER - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } rpt_t;

    rpt_t          st   [2];
    rpt_t          st_n [2];
    logic [TW-1:0] tmr  [2];
    logic [TW-1:0] tmr_n[2];

    // Repeat state and hold timers for up and down.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                st[i]  <= IDLE;
                tmr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                st[i]  <= st_n[i];
                tmr[i] <= tmr_n[i];
            end
        end
    end

    // Step on press, after the initial delay, then once per period.
    always_comb begin
        step = '0;
        for (int i = 0; i < 2; i++) begin
            st_n[i]  = st[i];
            tmr_n[i] = tmr[i];
            unique case (st[i])
                IDLE: begin
                    tmr_n[i] = '0;
                    if (press[i]) begin
                        step[i] = 1'b1;
                        st_n[i] = HOLD;
                    end
                end
                HOLD: begin
                    if (deb[i]) begin
                        st_n[i] = IDLE;
                    end else if (tmr[i] == DLY_LAST) begin
                        step[i]  = 1'b1;
                        st_n[i]  = REPEAT;
                        tmr_n[i] = '0;
                    end else begin
                        tmr_n[i] = tmr[i] + 1'b1;
                    end
                end
                REPEAT: begin
                    if (deb[i]) begin
                        st_n[i] = IDLE;
                    end else if (tmr[i] == PER_LAST) begin
                        step[i]  = 1'b1;
                        tmr_n[i] = '0;
                    end else begin
                        tmr_n[i] = tmr[i] + 1'b1;
                    end
                end
                default: st_n[i] = IDLE;
            endcase
        end
    end
`else
    logic unused_rpt;

    assign step       = press[1:0];
    assign unused_rpt = (RPT_DLY_MS + RPT_PER_MS) != 0;
`endif

    logic [WIDTH-1:0] count_q;
    logic [WIDTH:0]   cur;
    logic [WIDTH:0]   cnt_n;
    logic [3:0]       sel;
    logic             up_n;
    logic             dn_n;
    logic             wr_n;

    assign cur = {1'b0, count_q};
    assign sel = {
        clr_ev,
        ~clr_ev &  step[0] &  step[1],
        ~clr_ev &  step[0] & ~step[1],
        ~clr_ev & ~step[0] &  step[1]
    };

    // Next count: clear beats steps, opposing steps cancel.
    always_comb begin
        cnt_n = cur;
        up_n  = 1'b0;
        dn_n  = 1'b0;
        wr_n  = 1'b0;
        unique case (1'b1)
            sel[3]: cnt_n = MIN_W;
            sel[2]: cnt_n = cur;
            sel[1]: begin
                if (cur < MAX_W) begin
                    cnt_n = cur + 1'b1;
                    up_n  = 1'b1;
                end else if (WRAP != 0) begin
                    cnt_n = MIN_W;
                    up_n  = 1'b1;
                    wr_n  = 1'b1;
                end
            end
            sel[0]: begin
                if (cur > MIN_W) begin
                    cnt_n = cur - 1'b1;
                    dn_n  = 1'b1;
                end else if (WRAP != 0) begin
                    cnt_n = MAX_W;
                    dn_n  = 1'b1;
                    wr_n  = 1'b1;
                end
            end
            default: cnt_n = cur;
        endcase
    end

    logic up_q;
    logic dn_q;
    logic wr_q;
    logic max_q;
    logic min_q;

    // Count, pulses and limit flags all register on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= MIN_W[WIDTH-1:0];
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            wr_q    <= 1'b0;
            max_q   <= 1'b0;
            min_q   <= 1'b1;
        end else begin
            count_q <= cnt_n[WIDTH-1:0];
            up_q    <= up_n;
            dn_q    <= dn_n;
            wr_q    <= wr_n;
            max_q   <= (cnt_n == MAX_W);
            min_q   <= (cnt_n == MIN_W);
        end
    end

    assign bus.count      = count_q;
    assign bus.up_pulse   = up_q;
    assign bus.down_pulse = dn_q;
    assign bus.wrapped    = wr_q;
    assign bus.at_max     = max_q;
    assign bus.at_min     = min_q;
endmodule
